// File: rtl/main_bus_arbiter.sv
// main_bus_arbiter: round-robin arbiter for main_bus_if among NREQ masters.
// Grants one master per burst (1 address + DATAPAYLOADSIZE data + 1 turnaround)
// so the shared AddrData tristate bus is never driven by two masters.
// Ports:
//   clk, resetH        bus clock, async active-high reset
//   req[NREQ]          per-master level request, held until the burst is done
//   AddrValid, rw      monitored bus address strobe and direction (1=read)
//   gnt[NREQ]          one-hot grant, zero when no master owns the bus
//   owner              index of the current/last granted master
//   busy               high from grant until the end of turnaround
//   xfer_rd            rw latched on the address cycle of the current burst
//   timeout            1-cycle pulse: grant withdrawn, master never sent AddrValid
//   proto_err          1-cycle pulse: AddrValid seen outside the GRANT state
module main_bus_arbiter #(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned DATAPAYLOADSIZE = 4,
    parameter int unsigned GNT_TIMEOUT     = 8
) (
    input  logic                     clk,
    input  logic                     resetH,
    input  logic [NREQ-1:0]          req,
    input  logic                     AddrValid,
    input  logic                     rw,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic                     xfer_rd,
    output logic                     timeout,
    output logic                     proto_err
);

    localparam int unsigned OW   = $clog2(NREQ);
    localparam int unsigned CMAX = (GNT_TIMEOUT > DATAPAYLOADSIZE) ? GNT_TIMEOUT : DATAPAYLOADSIZE;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    if (NREQ < 2) begin : g_nreq_check
        $error("main_bus_arbiter: NREQ must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [OW-1:0]   owner_n;
    logic            busy_n, xfer_rd_n, timeout_n, proto_err_n;
    logic [OW-1:0]   rr, rr_n;
    logic [CW-1:0]   cnt, cnt_n;

    logic            win_found;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   owner_inc;

    // First requester at or above the rr pointer, wrapping at NREQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned k;
            k = (32'(rr) + i) % NREQ;
            if (!win_found && req[OW'(k)]) begin
                win_found = 1'b1;
                win_idx   = OW'(k);
            end
        end
    end

    // Pointer value that puts the current owner at lowest priority.
    assign owner_inc = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

    // State and registered outputs.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            xfer_rd   <= 1'b0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
            rr        <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            owner     <= owner_n;
            busy      <= busy_n;
            xfer_rd   <= xfer_rd_n;
            timeout   <= timeout_n;
            proto_err <= proto_err_n;
            rr        <= rr_n;
            cnt       <= cnt_n;
        end
    end

    // Next-state and next-output logic; cnt is the wait counter in GRANT
    // and the data-beat counter in XFER.
    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        owner_n     = owner;
        busy_n      = busy;
        xfer_rd_n   = xfer_rd;
        timeout_n   = 1'b0;
        proto_err_n = 1'b0;
        rr_n        = rr;
        cnt_n       = cnt;

        case (state)
            IDLE: begin
                proto_err_n = AddrValid;
                if (win_found) begin
                    state_n = GRANT;
                    gnt_n   = NREQ'(1) << win_idx;
                    owner_n = win_idx;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (AddrValid) begin
                    xfer_rd_n = rw;
                    cnt_n     = '0;
                    state_n   = XFER;
                end else if (!req[owner]) begin
                    // Master gave up before its address cycle: keep its priority.
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (cnt == CW'(GNT_TIMEOUT - 1)) begin
                    gnt_n     = '0;
                    busy_n    = 1'b0;
                    timeout_n = 1'b1;
                    rr_n      = owner_inc;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            XFER: begin
                proto_err_n = AddrValid;
                if (cnt == CW'(DATAPAYLOADSIZE - 1)) begin
                    gnt_n   = '0;
                    cnt_n   = '0;
                    state_n = TURN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            TURN: begin
                proto_err_n = AddrValid;
                busy_n      = 1'b0;
                rr_n        = owner_inc;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_main_bus_arbiter.sv
// tb_main_bus_arbiter: scoreboard bench for main_bus_arbiter (NREQ=4, D=4).
// Each stimulus cycle pushes the output snapshot expected after the next
// clock edge; a monitor pops and compares it after every rising edge.
module tb_main_bus_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       xfer_rd;
        logic       timeout;
        logic       proto_err;
    } snap_t;

    logic       clk;
    logic       resetH;
    logic [3:0] req;
    logic       AddrValid;
    logic       rw;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       xfer_rd;
    logic       timeout;
    logic       proto_err;

    int    vectors = 0;
    int    errors  = 0;
    snap_t sb[$];
    logic  xrd = 1'b0;

    main_bus_arbiter #(
        .NREQ(4),
        .DATAPAYLOADSIZE(4),
        .GNT_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .resetH(resetH),
        .req(req),
        .AddrValid(AddrValid),
        .rw(rw),
        .gnt(gnt),
        .owner(owner),
        .busy(busy),
        .xfer_rd(xfer_rd),
        .timeout(timeout),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [3:0] r, input logic av, input logic w,
                        input logic [3:0] eg, input logic [1:0] eo, input logic eb,
                        input logic ex, input logic et, input logic ep);
        snap_t e;
        @(negedge clk);
        req       = r;
        AddrValid = av;
        rw        = w;
        e = '{gnt: eg, owner: eo, busy: eb, xfer_rd: ex, timeout: et, proto_err: ep};
        sb.push_back(e);
    endtask

    // Full burst for master m starting from IDLE; perr_at selects a data beat
    // that also carries a stray AddrValid (-1 for none).
    task automatic burst(input logic [3:0] r, input logic [1:0] m, input logic rd,
                         input int perr_at, input logic [3:0] r_after);
        logic [3:0] g;
        g = 4'b0001 << m;
        step(r, 1'b0, 1'b0, g, m, 1'b1, xrd, 1'b0, 1'b0);
        xrd = rd;
        step(r, 1'b1, rd, g, m, 1'b1, xrd, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic av;
            av = (k == perr_at);
            step(r, av, 1'b0, (k == 3) ? 4'b0000 : g, m, 1'b1, xrd, 1'b0, av);
        end
        step(r_after, 1'b0, 1'b0, 4'b0000, m, 1'b0, xrd, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compare after each rising edge, away from the edge.
    always begin
        snap_t e;
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cycle_outputs", 32'({gnt, owner, busy, xfer_rd, timeout, proto_err}), 32'(e));
        end
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        resetH    = 1'b1;
        req       = 4'b1111;
        AddrValid = 1'b0;
        rw        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_owner", 32'(owner), 32'd0);
        resetH = 1'b0;

        // Round robin with all masters requesting.
        burst(4'b1111, 2'd0, 1'b1, -1, 4'b1111);
        burst(4'b1111, 2'd1, 1'b0, -1, 4'b1111);
        burst(4'b1111, 2'd2, 1'b1, -1, 4'b1111);
        burst(4'b1111, 2'd3, 1'b0, -1, 4'b1111);
        burst(4'b1111, 2'd0, 1'b1, -1, 4'b0000);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, xrd, 1'b0, 1'b0);

        // Single read from master 2.
        burst(4'b0100, 2'd2, 1'b1, -1, 4'b0000);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, xrd, 1'b0, 1'b0);

        // Write from master 3 with a stray AddrValid on the second data beat.
        burst(4'b1000, 2'd3, 1'b0, 1, 4'b0000);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, xrd, 1'b0, 1'b0);

        // AddrValid while idle.
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, xrd, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, xrd, 1'b0, 1'b0);

        // Grant timeout on master 1, then pointer wraps past 2,3 to master 0.
        for (int i = 0; i < 8; i++)
            step(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, xrd, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, xrd, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, xrd, 1'b0, 1'b0);
        // Master 0 withdraws; pointer must stay, so it wins again.
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, xrd, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, xrd, 1'b0, 1'b0);

        // Read burst aborted by reset at data counter 2.
        xrd = 1'b1;
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, xrd, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, xrd, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, xrd, 1'b0, 1'b0);
        @(negedge clk);
        resetH = 1'b1;
        req    = 4'b0000;
        #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_xfer_rd", 32'(xfer_rd), 32'd0);
        @(negedge clk);
        resetH = 1'b0;
        xrd    = 1'b0;
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, xrd, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, xrd, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, xrd, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
